// File: rtl/universal_shift_register.sv
// WIDTH-bit shift register with parallel load, selectable direction and a saturating fill count.
// One edge from LOAD or shift to Q; no backpressure, and CE=0 freezes all state.
module universal_shift_register #(
    parameter int               WIDTH = 6,
    parameter logic [WIDTH-1:0] INIT  = '0,
    localparam int              CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CE,
    input  logic             LOAD,
    input  logic             DIR,
    input  logic             SI,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic [CW-1:0]    COUNT,
    output logic             FULL
);

    localparam logic [CW-1:0] COUNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shl_val, shr_val;

    // A single stage has no neighbours, so both directions collapse to Q <= SI.
    generate
        if (WIDTH == 1) begin : g_w1
            assign shl_val = SI;
            assign shr_val = SI;
        end else begin : g_wn
            assign shl_val = {q_q[WIDTH-2:0], SI};
            assign shr_val = {SI, q_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        q_d     = q_q;
        count_d = count_q;
        if (CE) begin
            if (LOAD) begin
                q_d     = D;
                count_d = COUNT_MAX;
            end else begin
                q_d = DIR ? shr_val : shl_val;
                if (count_q != COUNT_MAX) begin
                    count_d = count_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q     <= INIT;
            count_q <= '0;
        end else begin
            q_q     <= q_d;
            count_q <= count_d;
        end
    end

    assign Q     = q_q;
    assign COUNT = count_q;
    assign SO    = DIR ? q_q[0] : q_q[WIDTH-1];
    assign FULL  = (count_q == COUNT_MAX);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench over four instances (6-bit legacy, 8-bit, 6-bit with INIT, 1-bit), scoreboard-checked.
module tb_universal_shift_register;

    logic       CLK = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0;
    logic       load = 1'b0;
    logic       dir = 1'b0;
    logic       si = 1'b0;
    logic [7:0] d = 8'h00;

    logic [5:0] q0, q2;
    logic [7:0] q1;
    logic [0:0] q3;
    logic [2:0] c0, c2;
    logic [3:0] c1;
    logic [0:0] c3;
    logic       so0, so1, so2, so3;
    logic       f0, f1, f2, f3;

    always #5 CLK = ~CLK;

    universal_shift_register #(.WIDTH(6), .INIT(6'h00)) u_w6 (
        .CLK(CLK), .RESET(rst), .CE(ce), .LOAD(load), .DIR(dir), .SI(si),
        .D(d[5:0]), .Q(q0), .SO(so0), .COUNT(c0), .FULL(f0));
    universal_shift_register #(.WIDTH(8), .INIT(8'h00)) u_w8 (
        .CLK(CLK), .RESET(rst), .CE(ce), .LOAD(load), .DIR(dir), .SI(si),
        .D(d), .Q(q1), .SO(so1), .COUNT(c1), .FULL(f1));
    universal_shift_register #(.WIDTH(6), .INIT(6'h2A)) u_w6i (
        .CLK(CLK), .RESET(rst), .CE(ce), .LOAD(load), .DIR(dir), .SI(si),
        .D(d[5:0]), .Q(q2), .SO(so2), .COUNT(c2), .FULL(f2));
    universal_shift_register #(.WIDTH(1), .INIT(1'b1)) u_w1 (
        .CLK(CLK), .RESET(rst), .CE(ce), .LOAD(load), .DIR(dir), .SI(si),
        .D(d[0:0]), .Q(q3), .SO(so3), .COUNT(c3), .FULL(f3));

    typedef struct {
        string      name;
        int         tag;
        logic [7:0] q;
        logic [7:0] cnt;
        logic       so;
        logic       full;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    function automatic int width_of(input int tag);
        case (tag)
            0: return 6;
            1: return 8;
            2: return 6;
            default: return 1;
        endcase
    endfunction

    // Monitor: everything queued this cycle is compared half a period after the edge.
    exp_t       e;
    logic [7:0] aq, ac;
    logic       aso, af;
    always @(negedge CLK) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.tag)
                0: begin aq = {2'b00, q0}; ac = {5'd0, c0}; aso = so0; af = f0; end
                1: begin aq = q1; ac = {4'd0, c1}; aso = so1; af = f1; end
                2: begin aq = {2'b00, q2}; ac = {5'd0, c2}; aso = so2; af = f2; end
                default: begin aq = {7'd0, q3}; ac = {7'd0, c3}; aso = so3; af = f3; end
            endcase
            total++;
            if (aq !== e.q || ac !== e.cnt || aso !== e.so || af !== e.full) begin
                bad++;
                $display("FAIL %s: got q=%h count=%0d so=%b full=%b, want q=%h count=%0d so=%b full=%b",
                         e.name, aq, ac, aso, af, e.q, e.cnt, e.so, e.full);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1; ce = 1'b0; load = 1'b0; dir = 1'b0; si = 1'b0; d = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    // Apply inputs for one edge and queue the state expected to be visible before that edge.
    task automatic cyc(input string name, input int tag, input logic rst_v, input logic ce_v,
                       input logic load_v, input logic dir_v, input logic si_v, input logic [7:0] d_v,
                       input logic [7:0] eq, input int ec, input logic eso);
        exp_t x;
        rst = rst_v; ce = ce_v; load = load_v; dir = dir_v; si = si_v; d = d_v;
        x.name = name; x.tag = tag; x.q = eq; x.cnt = 8'(ec); x.so = eso;
        x.full = (ec == width_of(tag));
        sb.push_back(x);
        tick();
    endtask

    initial begin
        // Legacy 6-stage SISO: SI 1,0,1,1,0,0,1 reappears on SO six edges later.
        reset_all();
        cyc("legacy0",  0, 0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        cyc("legacy1",  0, 0, 1, 0, 0, 0, 8'h00, 8'h01, 1, 0);
        cyc("legacy2",  0, 0, 1, 0, 0, 1, 8'h00, 8'h02, 2, 0);
        cyc("legacy3",  0, 0, 1, 0, 0, 1, 8'h00, 8'h05, 3, 0);
        cyc("legacy4",  0, 0, 1, 0, 0, 0, 8'h00, 8'h0B, 4, 0);
        cyc("legacy5",  0, 0, 1, 0, 0, 0, 8'h00, 8'h16, 5, 0);
        cyc("legacy6",  0, 0, 1, 0, 0, 1, 8'h00, 8'h2C, 6, 1);
        cyc("legacy7",  0, 0, 1, 0, 0, 0, 8'h00, 8'h19, 6, 0);
        cyc("legacy8",  0, 0, 1, 0, 0, 0, 8'h00, 8'h32, 6, 1);
        cyc("legacy9",  0, 0, 1, 0, 0, 0, 8'h00, 8'h24, 6, 1);
        cyc("legacy10", 0, 0, 1, 0, 0, 0, 8'h00, 8'h08, 6, 0);
        cyc("legacy11", 0, 0, 1, 0, 0, 0, 8'h00, 8'h10, 6, 0);
        cyc("legacy12", 0, 0, 0, 0, 0, 0, 8'h00, 8'h20, 6, 1);

        // CE=0 freezes a partially filled count too; DIR still steers SO.
        reset_all();
        cyc("gate_cnt0", 0, 0, 1, 0, 0, 1, 8'h00, 8'h00, 0, 0);
        cyc("gate_cnt1", 0, 0, 0, 1, 0, 0, 8'h3F, 8'h01, 1, 0);
        cyc("gate_cnt2", 0, 0, 0, 0, 0, 1, 8'h3F, 8'h01, 1, 0);
        cyc("gate_cnt3", 0, 0, 0, 1, 1, 0, 8'h3F, 8'h01, 1, 1);
        cyc("gate_cnt4", 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 1, 0);

        // Load 0xA5 then shift right, LSB first out of SO.
        reset_all();
        cyc("load_a5", 1, 0, 1, 1, 0, 0, 8'hA5, 8'h00, 0, 0);
        cyc("shr0", 1, 0, 1, 0, 1, 0, 8'h00, 8'hA5, 8, 1);
        cyc("shr1", 1, 0, 1, 0, 1, 0, 8'h00, 8'h52, 8, 0);
        cyc("shr2", 1, 0, 1, 0, 1, 0, 8'h00, 8'h29, 8, 1);
        cyc("shr3", 1, 0, 1, 0, 1, 0, 8'h00, 8'h14, 8, 0);
        cyc("shr4", 1, 0, 1, 0, 1, 0, 8'h00, 8'h0A, 8, 0);
        cyc("shr5", 1, 0, 1, 0, 1, 0, 8'h00, 8'h05, 8, 1);
        cyc("shr6", 1, 0, 1, 0, 1, 0, 8'h00, 8'h02, 8, 0);
        cyc("shr7", 1, 0, 1, 0, 1, 0, 8'h00, 8'h01, 8, 1);

        // Load 0x3C then shift left with SI=1.
        cyc("load_3c", 1, 0, 1, 1, 0, 0, 8'h3C, 8'h00, 8, 0);
        cyc("shl0", 1, 0, 1, 0, 0, 1, 8'h00, 8'h3C, 8, 0);
        cyc("shl1", 1, 0, 1, 0, 0, 1, 8'h00, 8'h79, 8, 0);
        cyc("shl2", 1, 0, 1, 0, 0, 1, 8'h00, 8'hF3, 8, 1);
        cyc("shl3", 1, 0, 1, 0, 0, 1, 8'h00, 8'hE7, 8, 1);

        // Enable gating on a full register, then load beats shift.
        cyc("load_5a", 1, 0, 1, 1, 0, 0, 8'h5A, 8'hCF, 8, 1);
        cyc("hold0", 1, 0, 0, 1, 0, 1, 8'hFF, 8'h5A, 8, 0);
        cyc("hold1", 1, 0, 0, 0, 0, 0, 8'hFF, 8'h5A, 8, 0);
        cyc("hold2", 1, 0, 0, 1, 0, 1, 8'hFF, 8'h5A, 8, 0);
        cyc("hold3", 1, 0, 0, 0, 0, 0, 8'hFF, 8'h5A, 8, 0);
        cyc("hold4", 1, 0, 0, 1, 0, 1, 8'hFF, 8'h5A, 8, 0);
        cyc("load_wins", 1, 0, 1, 1, 0, 1, 8'hFF, 8'h5A, 8, 0);

        // Direction switching each edge after loading 0x81.
        cyc("load_81", 1, 0, 1, 1, 0, 0, 8'h81, 8'hFF, 8, 1);
        cyc("dsw0", 1, 0, 1, 0, 1, 0, 8'h00, 8'h81, 8, 1);
        cyc("dsw1", 1, 0, 1, 0, 0, 0, 8'h00, 8'h40, 8, 0);
        cyc("dsw2", 1, 0, 1, 0, 1, 0, 8'h00, 8'h80, 8, 0);
        cyc("dsw3", 1, 0, 1, 0, 0, 0, 8'h00, 8'h40, 8, 0);
        cyc("dsw_so_l", 1, 0, 0, 0, 0, 0, 8'h00, 8'h80, 8, 1);
        cyc("dsw_so_r", 1, 0, 0, 0, 1, 0, 8'h00, 8'h80, 8, 0);

        // Reset mid-shift on the INIT=0x2A instance overrides a concurrent load.
        reset_all();
        cyc("rmid0", 2, 0, 1, 0, 0, 1, 8'h00, 8'h2A, 0, 1);
        cyc("rmid1", 2, 0, 1, 0, 0, 1, 8'h00, 8'h15, 1, 0);
        cyc("rmid2", 2, 0, 1, 0, 0, 0, 8'h00, 8'h2B, 2, 1);
        cyc("rmid_rst", 2, 1, 1, 1, 0, 0, 8'h3F, 8'h16, 3, 0);
        cyc("rmid_after", 2, 0, 0, 0, 0, 0, 8'h00, 8'h2A, 0, 1);

        // Single-stage register: both directions are Q <= SI, FULL tracks COUNT.
        reset_all();
        cyc("w1_0", 3, 0, 1, 0, 0, 0, 8'h00, 8'h01, 0, 1);
        cyc("w1_1", 3, 0, 1, 0, 1, 1, 8'h00, 8'h00, 1, 0);
        cyc("w1_2", 3, 0, 1, 0, 0, 0, 8'h00, 8'h01, 1, 1);
        cyc("w1_3", 3, 0, 1, 1, 0, 0, 8'h01, 8'h00, 1, 0);
        cyc("w1_4", 3, 0, 0, 0, 0, 0, 8'h00, 8'h01, 1, 1);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge CLK);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
